dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Controller that shares the single-port word-organised data memory between two requesters: the core load/store unit (port 0) and the DMA/loader (port 1). It arbitrates with round-robin priority and sequences each access. Byte and halfword stores are turned into read-modify-write pairs because the memory only writes whole words. It sits between the requesters and the data memory, which reads combinationally and writes on the clock edge.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; fixed at 32 (four byte lanes).
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid[p]` in 1 (p = 0, 1): request present.
- `req_ready[p]` out 1: request accepted this cycle.
- `req_write[p]` in 1: 1 = store, 0 = load.
- `req_size[p]` in 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `req_signed[p]` in 1: sign-extend sub-word loads.
- `req_addr[p]` in ADDR_W: byte address.
- `req_wdata[p]` in DATA_W: store data, right-justified.
- `resp_valid[p]` out 1: one-cycle completion pulse.
- `resp_rdata[p]` out DATA_W: load data, right-justified and extended.
- `resp_err[p]` out 1: misaligned access; valid with `resp_valid`.
- `mem_adr` out ADDR_W: word address to memory, with bits [1:0] = 00.
- `mem_wdata` out DATA_W: word to write.
- `mem_write` out 1: write strobe.
- `mem_rdata` in DATA_W: combinational read data.

## Operation
- Lane mapping: the byte at address offset k (addr[1:0] = k) is `mem_rdata[31-8k -: 8]`. A half at addr[1] = 0 occupies [31:16]; at addr[1] = 1 it occupies [15:0].
- States:
  - IDLE → EXEC on accept.
  - EXEC → RMW for a sub-word store; otherwise EXEC → RESP.
  - RMW → RESP.
  - RESP → IDLE.
- Accept happens only in IDLE.
  - `req_ready` is high for exactly one port: the arbitration winner, and only when that port's `req_valid` is high.
  - The request fields are latched on accept.
- Arbitration is round-robin.
  - After a grant to port p, port 1-p has priority on the next contention.
  - The priority pointer resets to port 0.
  - A lone requester always wins.
- EXEC:
  - `mem_adr` = {addr[31:2], 00}.
  - Load: extract the addressed lane from `mem_rdata` and register the result. Sub-word loads are zero-extended unless `req_signed` is set.
  - Word store: `mem_write` = 1 and `mem_wdata` = `req_wdata`.
  - Sub-word store: `mem_write` = 0; register `mem_rdata` with the new lane merged in.
- RMW: `mem_adr` held; `mem_write` = 1; `mem_wdata` = the merged word.
- RESP:
  - `resp_valid[p]` = 1 for the served port only.
  - `resp_rdata` is valid for loads and 0 for stores.
- `mem_write`, `mem_adr` and `mem_wdata` decode from the state and the latched request. `mem_write` is 0 in IDLE and RESP.
- Reset values:
  - State IDLE; priority pointer 0.
  - All `req_ready`, `resp_valid`, `resp_err`, `resp_rdata` = 0.
  - `mem_write` = 0, `mem_adr` = 0, `mem_wdata` = 0.
- Reset mid-operation: state goes to IDLE immediately and asynchronously. A pending RMW write is abandoned (`mem_write` drops without waiting for a clock edge). No response is issued for the aborted request.
- A requester may hold `req_valid` during its own outstanding access. A second request is not accepted until IDLE.

## Timing
- Accept in cycle N → EXEC in N+1.
- Load or word store: `resp_valid` in N+2.
- Sub-word store: memory write at the end of N+2; `resp_valid` in N+3.
- Throughput: one access every 3 cycles for loads and word stores, every 4 cycles for sub-word stores.
- Simultaneous valid on both ports in IDLE: one `req_ready` only. The loser keeps `req_valid` and is accepted at the next IDLE.

## Configuration
- `DMEM_ARB_MISALIGN_CHECK_EN`, defined: a half with addr[0] = 1 or a word with addr[1:0] ≠ 00 skips memory entirely.
  - Path: EXEC → RESP with `mem_write` = 0.
  - Response: `resp_err` = 1, `resp_rdata` = 0.
- `DMEM_ARB_MISALIGN_CHECK_EN`, undefined:
  - `resp_err` is tied to 0.
  - Illegal low bits are ignored: addr[0] for halves, addr[1:0] for words.

## Structure
- Package `dmem_arb_pkg` holds:
  - the size encoding;
  - the state enum;
  - lane extract/merge functions.
- Sub-module `dmem_rr_arbiter` holds the two-request round-robin grant and priority pointer. The FSM and datapath stay in `dmem_arbiter`.

## Test plan
- Memory word at 0x100 = 0x11223344. Port 0 loads a byte from 0x101, unsigned → `resp_rdata` = 0x00000022 at N+2. The same load signed from 0x100 with word 0x80xxxxxx → 0xFFFFFF80.
- Port 1 stores half 0xBEEF at 0x102 with word 0x11223344 → `mem_write` high only in N+2 with `mem_wdata` = 0x1122BEEF. `resp_valid[1]` at N+3.
- Both ports valid continuously, loads → grants alternate 0, 1, 0, 1. Each `resp_valid` pulses one cycle to the correct port.
- Assert `rst` during RMW → `mem_write` low the same cycle and memory unchanged. After release, the next request is granted to port 0.
- With `DMEM_ARB_MISALIGN_CHECK_EN`, a word store to 0x103 → no `mem_write`; `resp_err` = 1 at N+2. Without the macro, the store writes the word at 0x100.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and lane helpers for the two-port data-memory arbiter.
// Byte lane k sits at word bits [31-8k -: 8]; the half at addr[1]=0 is the upper half.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RMW  = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input size_e       size,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  off,
                                               input size_e       size);
        logic [31:0] r;
        r = old;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    r[31:24] = wdata[7:0];
                    2'd1:    r[23:16] = wdata[7:0];
                    2'd2:    r[15:8]  = wdata[7:0];
                    default: r[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) r[15:0]  = wdata[15:0];
                else        r[31:16] = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] off, input size_e size);
        return ((size == SZ_HALF) && off[0]) ||
               (((size == SZ_WORD) || (size == SZ_RSVD)) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-side signals of the two-port data-memory arbiter.
// slave = arbiter side; master = requesters plus the memory model.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_write;
    logic [1:0]        req_size   [2];
    logic [1:0]        req_signed;
    logic [ADDR_W-1:0] req_addr   [2];
    logic [DATA_W-1:0] req_wdata  [2];
    logic [1:0]        resp_valid;
    logic [DATA_W-1:0] resp_rdata [2];
    logic [1:0]        resp_err;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_adr, mem_wdata, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_adr, mem_wdata, mem_write
    );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// Two-request round-robin grant; the priority pointer flips to the loser after each grant.
module dmem_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       enable_i,
    output logic [1:0] grant_o,
    output logic       grant_idx_o
);
    logic prio_q, prio_d;

    always_comb begin
        grant_idx_o = 1'b0;
        if (valid_i[0] && valid_i[1]) grant_idx_o = prio_q;
        else if (valid_i[1])          grant_idx_o = 1'b1;

        grant_o = 2'b00;
        if (enable_i && valid_i[grant_idx_o]) grant_o[grant_idx_o] = 1'b1;

        prio_d = prio_q;
        if (|grant_o) prio_d = ~grant_idx_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prio_q <= 1'b0;
        else     prio_q <= prio_d;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port word memory between two requesters; sub-word stores become RMW pairs.
// Optional build macro DMEM_ARB_MISALIGN_CHECK_EN turns misaligned halves/words into errors.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    state_e            state_q, state_d;
    logic              port_q, write_q, signed_q;
    size_e             size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, data_q, data_d;
    logic [1:0]        grant;
    logic              grant_idx, accept, subword, misalign;
    logic [1:0]        off;
    logic [ADDR_W-1:0] word_adr;

    dmem_rr_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (bus.req_valid),
        .enable_i   (state_q == ST_IDLE),
        .grant_o    (grant),
        .grant_idx_o(grant_idx)
    );

    assign accept        = |grant;
    assign bus.req_ready = grant;
    assign off           = addr_q[1:0];
    assign word_adr      = {addr_q[ADDR_W-1:2], 2'b00};
    assign subword       = (size_q == SZ_BYTE) || (size_q == SZ_HALF);

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    logic err_q;
    assign misalign = is_misaligned(off, size_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     err_q <= 1'b0;
        else if (state_q == ST_EXEC) err_q <= misalign;
    end
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            port_q   <= 1'b0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SZ_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            if (accept) begin
                port_q   <= grant_idx;
                write_q  <= bus.req_write[grant_idx];
                signed_q <= bus.req_signed[grant_idx];
                size_q   <= size_e'(bus.req_size[grant_idx]);
                addr_q   <= bus.req_addr[grant_idx];
                wdata_q  <= bus.req_wdata[grant_idx];
            end
        end
    end

    // data_q holds the extracted load value, or the merged word awaiting the RMW write
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        bus.mem_write = 1'b0;
        bus.mem_adr   = '0;
        bus.mem_wdata = '0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: begin
                bus.mem_adr = word_adr;
                state_d     = ST_RESP;
                if (misalign) begin
                    data_d = '0;
                end else if (!write_q) begin
                    data_d = lane_extract(bus.mem_rdata, off, size_q, signed_q);
                end else if (subword) begin
                    data_d  = lane_merge(bus.mem_rdata, wdata_q, off, size_q);
                    state_d = ST_RMW;
                end else begin
                    bus.mem_write = 1'b1;
                    bus.mem_wdata = wdata_q;
                end
            end
            ST_RMW: begin
                bus.mem_adr   = word_adr;
                bus.mem_write = 1'b1;
                bus.mem_wdata = data_q;
                state_d       = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            bus.resp_valid[p] = 1'b0;
            bus.resp_rdata[p] = '0;
            bus.resp_err[p]   = 1'b0;
            if (state_q == ST_RESP && port_q == 1'(p)) begin
                bus.resp_valid[p] = 1'b1;
                if (!write_q) bus.resp_rdata[p] = data_q;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
                bus.resp_err[p] = err_q;
`endif
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single accesses plus
// hand-written contention and reset-during-RMW sequences, with a local word memory.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    assign bus.mem_rdata = mem[bus.mem_adr[9:2]];

    always @(posedge clk) begin
        if (pl_en)              mem[pl_idx] <= pl_data;
        else if (bus.mem_write) mem[bus.mem_adr[9:2]] <= bus.mem_wdata;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pl_idx  = addr[9:2];
        pl_data = data;
        pl_en   = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rd;
        logic [31:0] exp_mem;
        logic        exp_err;
        int          exp_lat;
        int          exp_wcyc;
    } vec_t;

    function automatic vec_t mk(input logic port, input logic wr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] init, input logic [31:0] exp_rd,
                                input logic [31:0] exp_mem, input logic exp_err,
                                input int exp_lat, input int exp_wcyc);
        vec_t v;
        v.port = port; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.init = init; v.exp_rd = exp_rd; v.exp_mem = exp_mem; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_wcyc = exp_wcyc;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int          o, lat, wcyc, wcnt, other, tries;
        logic [31:0] rd;
        logic        err, got;
        o = v.port ? 0 : 1;
        lat = 0; wcyc = 0; wcnt = 0; other = 0; rd = '0; err = 1'b0; got = 1'b0;
        preload(v.addr, v.init);
        bus.req_valid[o]       = 1'b0;
        bus.req_write[v.port]  = v.wr;
        bus.req_size[v.port]   = v.size;
        bus.req_signed[v.port] = v.sgn;
        bus.req_addr[v.port]   = v.addr;
        bus.req_wdata[v.port]  = v.wdata;
        bus.req_valid[v.port]  = 1'b1;
        for (tries = 0; tries < 8 && !got; tries++) begin
            @(negedge clk);
            if (bus.req_ready[v.port]) got = 1'b1;
        end
        chk($sformatf("v%0d accept", id), {31'b0, got}, 32'd1);
        if (!got) begin
            bus.req_valid[v.port] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid[v.port] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.mem_write) begin wcnt++; wcyc = k; end
            if (bus.resp_valid[o]) other++;
            if (bus.resp_valid[v.port] && lat == 0) begin
                lat = k;
                rd  = bus.resp_rdata[v.port];
                err = bus.resp_err[v.port];
            end
        end
        if (wcnt > 1) wcyc = 99;
        chk($sformatf("v%0d latency", id), lat, v.exp_lat);
        chk($sformatf("v%0d rdata", id), rd, v.exp_rd);
        chk($sformatf("v%0d err", id), {31'b0, err}, {31'b0, v.exp_err});
        chk($sformatf("v%0d write_cycle", id), wcyc, v.exp_wcyc);
        chk($sformatf("v%0d other_resp", id), other, 0);
        chk($sformatf("v%0d mem_word", id), mem[v.addr[9:2]], v.exp_mem);
    endtask

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          ng, nr, both;
        int          gport[8], gcyc[8], rport[8], rcyc[8];
        logic [31:0] rdat[8];

        vecs[0]  = mk(0, 0, 2'b00, 0, 32'h101, 32'h0, 32'h11223344, 32'h00000022, 32'h11223344, 0, 2, 0);
        vecs[1]  = mk(0, 0, 2'b00, 1, 32'h100, 32'h0, 32'h80112233, 32'hFFFFFF80, 32'h80112233, 0, 2, 0);
        vecs[2]  = mk(1, 1, 2'b01, 0, 32'h102, 32'h0000BEEF, 32'h11223344, 32'h0, 32'h1122BEEF, 0, 3, 2);
        vecs[3]  = mk(0, 0, 2'b01, 1, 32'h100, 32'h0, 32'h11223344, 32'h00001122, 32'h11223344, 0, 2, 0);
        vecs[4]  = mk(1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h1122F344, 32'hFFFFF344, 32'h1122F344, 0, 2, 0);
        vecs[5]  = mk(1, 0, 2'b10, 0, 32'h104, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 0, 2, 0);
        vecs[6]  = mk(0, 1, 2'b00, 0, 32'h103, 32'hFFFFFFAB, 32'h11223344, 32'h0, 32'h112233AB, 0, 3, 2);
        vecs[7]  = mk(1, 1, 2'b00, 0, 32'h100, 32'h0000005A, 32'h11223344, 32'h0, 32'h5A223344, 0, 3, 2);
        vecs[8]  = mk(0, 1, 2'b10, 0, 32'h108, 32'hDEADBEEF, 32'h01020304, 32'h0, 32'hDEADBEEF, 0, 2, 1);
        vecs[9]  = mk(0, 0, 2'b00, 0, 32'h10E, 32'h0, 32'h1122A344, 32'h000000A3, 32'h1122A344, 0, 2, 0);
        vecs[10] = mk(1, 0, 2'b11, 0, 32'h110, 32'h0, 32'h76543210, 32'h76543210, 32'h76543210, 0, 2, 0);
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
        vecs[11] = mk(0, 1, 2'b10, 0, 32'h103, 32'hA5A5A5A5, 32'h11223344, 32'h0, 32'h11223344, 1, 2, 0);
        vecs[12] = mk(1, 0, 2'b01, 0, 32'h101, 32'h0, 32'h11223344, 32'h0, 32'h11223344, 1, 2, 0);
        vecs[13] = mk(0, 0, 2'b01, 1, 32'h103, 32'h0, 32'h1122F344, 32'h0, 32'h1122F344, 1, 2, 0);
`else
        vecs[11] = mk(0, 1, 2'b10, 0, 32'h103, 32'hA5A5A5A5, 32'h11223344, 32'h0, 32'hA5A5A5A5, 0, 2, 1);
        vecs[12] = mk(1, 0, 2'b01, 0, 32'h101, 32'h0, 32'h11223344, 32'h00001122, 32'h11223344, 0, 2, 0);
        vecs[13] = mk(0, 0, 2'b01, 1, 32'h103, 32'h0, 32'h1122F344, 32'hFFFFF344, 32'h1122F344, 0, 2, 0);
`endif

        bus.req_valid  = 2'b00;
        bus.req_write  = 2'b00;
        bus.req_signed = 2'b00;
        for (int p = 0; p < 2; p++) begin
            bus.req_size[p]  = 2'b10;
            bus.req_addr[p]  = '0;
            bus.req_wdata[p] = '0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst req_ready", {30'b0, bus.req_ready}, 32'd0);
        chk("rst resp_valid", {30'b0, bus.resp_valid}, 32'd0);
        chk("rst resp_err", {30'b0, bus.resp_err}, 32'd0);
        chk("rst mem_write", {31'b0, bus.mem_write}, 32'd0);
        chk("rst mem_adr", bus.mem_adr, 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst resp_rdata0", bus.resp_rdata[0], 32'd0);
        chk("rst resp_rdata1", bus.resp_rdata[1], 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Contention: both ports hold load requests; grants must alternate from port 0
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        preload(32'h110, 32'hAAAA0000);
        preload(32'h114, 32'h0000BBBB);
        bus.req_write = 2'b00;
        bus.req_size[0] = 2'b10; bus.req_addr[0] = 32'h110;
        bus.req_size[1] = 2'b10; bus.req_addr[1] = 32'h114;
        bus.req_valid = 2'b11;
        ng = 0; nr = 0; both = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.req_ready == 2'b11) both++;
            for (int p = 0; p < 2; p++) begin
                if (bus.req_ready[p] && ng < 8) begin gport[ng] = p; gcyc[ng] = c; ng++; end
                if (bus.resp_valid[p] && nr < 8) begin
                    rport[nr] = p; rcyc[nr] = c; rdat[nr] = bus.resp_rdata[p]; nr++;
                end
            end
        end
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        chk("rr double_ready", both, 0);
        chk("rr grant_count", ng, 5);
        chk("rr resp_count", nr, 5);
        for (int i = 0; i < 5 && i < ng && i < nr; i++) begin
            chk($sformatf("rr grant%0d port", i), gport[i], i % 2);
            chk($sformatf("rr grant%0d cycle", i), gcyc[i], 3 * i);
            chk($sformatf("rr resp%0d port", i), rport[i], i % 2);
            chk($sformatf("rr resp%0d cycle", i), rcyc[i], 3 * i + 2);
            chk($sformatf("rr resp%0d data", i), rdat[i], (i % 2) ? 32'h0000BBBB : 32'hAAAA0000);
        end
        repeat (4) @(posedge clk);

        // Reset asserted while the RMW write is on the bus
        preload(32'h120, 32'h11223344);
        bus.req_write[0] = 1'b1; bus.req_size[0] = 2'b00; bus.req_signed[0] = 1'b0;
        bus.req_addr[0] = 32'h120; bus.req_wdata[0] = 32'h00000099;
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        chk("rmwrst accept", {30'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmwrst write_before", {31'b0, bus.mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rmwrst write_dropped", {31'b0, bus.mem_write}, 32'd0);
        chk("rmwrst no_resp", {30'b0, bus.resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("rmwrst mem_unchanged", mem[8'h48], 32'h11223344);
        rst = 1'b0;
        bus.req_write = 2'b00;
        bus.req_addr[1] = 32'h114;
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("rmwrst grant_after", {30'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        repeat (4) @(posedge clk);
        chk("rmwrst mem_final", mem[8'h48], 32'h11223344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
